// File: rtl/dcoffset_pkg.sv
// Shared widths, reset code, FSM encoding and slew arithmetic for the DC-offset loader.
package dcoffset_pkg;

  localparam int DAC_W   = 12;
  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 4;

  localparam logic [DAC_W-1:0] DC_ZERO = 12'h800;

  typedef enum logic [1:0] {IDLE, SLEW, ALIGN} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DAC_W-1:0]  data;
  } frame_t;

  // One bounded move from cur toward tgt; the step is clipped to the remaining
  // distance, so the result can neither overshoot nor wrap.
  function automatic logic [DAC_W-1:0] slew_next(input logic [DAC_W-1:0] cur,
                                                 input logic [DAC_W-1:0] tgt,
                                                 input logic [DAC_W-1:0] step);
    logic [DAC_W:0]   diff;
    logic [DAC_W-1:0] mag;
    logic [DAC_W-1:0] delta;
    diff  = {1'b0, tgt} - {1'b0, cur};
    mag   = diff[DAC_W] ? (cur - tgt) : (tgt - cur);
    delta = (mag < step) ? mag : step;
    return diff[DAC_W] ? (cur - delta) : (cur + delta);
  endfunction

endpackage

// File: rtl/dcoffset_loader_if.sv
// MCU serial link in, offset path strobe/data out.
interface dcoffset_loader_if;
  import dcoffset_pkg::*;

  logic             SCK;
  logic             SDI;
  logic             CS_n;
  logic [DAC_W-1:0] Dout;
  logic             EN;
  logic             Busy;
  logic             FrameErr;

  modport master (output SCK, SDI, CS_n, input Dout, EN, Busy, FrameErr);
  modport slave  (input SCK, SDI, CS_n, output Dout, EN, Busy, FrameErr);
endinterface

// File: rtl/serial_frame_rx.sv
// 3-wire serial frame receiver: synchronizers, MSB-first shifter, bit count,
// one-cycle frame_valid on a 16-bit frame and frame_err on any other length.
module serial_frame_rx
  import dcoffset_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   sck,
  input  logic   sdi,
  input  logic   cs_n,
  output logic   frame_valid,
  output frame_t frame,
  output logic   frame_err
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  // [1:0] is the two-flop synchronizer, [2] is the edge-detect history
  logic [2:0]         sck_sync_q, sck_sync_d;
  logic [2:0]         sdi_sync_q, sdi_sync_d;
  logic [2:0]         cs_sync_q, cs_sync_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fv_q, fv_d;
  logic               ferr_q, ferr_d;
  frame_t             frame_q, frame_d;
  logic               sck_rise, cs_fall, cs_rise;

  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], sck};
    sdi_sync_d = {sdi_sync_q[1:0], sdi};
    cs_sync_d  = {cs_sync_q[1:0], cs_n};
    sck_rise   = sck_sync_q[1] & ~sck_sync_q[2];
    cs_fall    = ~cs_sync_q[1] & cs_sync_q[2];
    cs_rise    = cs_sync_q[1] & ~cs_sync_q[2];
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    fv_d       = 1'b0;
    ferr_d     = 1'b0;
    if (cs_fall) begin
      cnt_d = '0;
    end else if (sck_rise && !cs_sync_q[1]) begin
      shreg_d = {shreg_q[FRAME_W-2:0], sdi_sync_q[1]};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
    if (cs_rise) begin
      if (cnt_q == CNT_FULL) begin
        fv_d    = 1'b1;
        frame_d = frame_t'(shreg_q);
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  // CS_n history resets high so an idle bus produces no edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= '1;
      shreg_q    <= '0;
      cnt_q      <= '0;
      frame_q    <= '0;
      fv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      cs_sync_q  <= cs_sync_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      fv_q       <= fv_d;
      ferr_q     <= ferr_d;
    end
  end

  assign frame_valid = fv_q;
  assign frame       = frame_q;
  assign frame_err   = ferr_q;

endmodule

// File: rtl/dcoffset_loader.sv
// DC-offset loader: slews the applied code toward the MCU target in bounded
// steps and strobes EN a fixed delay after each Dout update.
module dcoffset_loader
  import dcoffset_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR     = 4'hA,
  parameter int                STEP     = 16,
  parameter int                TICK_DIV = 64,
  parameter int                EN_DELAY = 2
)(
  input  logic              Clock,
  input  logic              Reset_n,
  dcoffset_loader_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(EN_DELAY + 1);
  localparam logic [DAC_W-1:0] STEP_C = DAC_W'(STEP);

  logic             frame_valid;
  logic             frame_err;
  frame_t           frame;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic [DAC_W-1:0] cur_q, cur_d;
  logic [DAC_W-1:0] tgt_q, tgt_d;
  logic             en_q, en_d;
  logic             tick;

  serial_frame_rx u_rx (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .sck         (bus.SCK),
    .sdi         (bus.SDI),
    .cs_n        (bus.CS_n),
    .frame_valid (frame_valid),
    .frame       (frame),
    .frame_err   (frame_err)
  );

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // ALIGN spans EN_DELAY+1 cycles so Busy is still high during the EN cycle
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    acnt_d  = acnt_q;
    en_d    = 1'b0;
    if (frame_valid && frame.addr == ADDR) tgt_d = frame.data;
    unique case (state_q)
      IDLE: begin
        if (tgt_q != cur_q) state_d = SLEW;
      end
      SLEW: begin
        if (tgt_q == cur_q) begin
          state_d = IDLE;
        end else if (tick) begin
          cur_d   = slew_next(cur_q, tgt_q, STEP_C);
          acnt_d  = '0;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        acnt_d = acnt_q + 1'b1;
        if (acnt_q == AW'(EN_DELAY - 1)) en_d = 1'b1;
        if (acnt_q == AW'(EN_DELAY)) state_d = (cur_q != tgt_q) ? SLEW : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      acnt_q  <= '0;
      cur_q   <= DC_ZERO;
      tgt_q   <= DC_ZERO;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      en_q    <= en_d;
    end
  end

  // Dout is the applied code itself; it only moves on a SLEW tick
  assign bus.Dout     = cur_q;
  assign bus.EN       = en_q;
  assign bus.Busy     = (state_q != IDLE) || (tgt_q != cur_q);
  assign bus.FrameErr = frame_err;

endmodule

// File: tb/tb_dcoffset_loader.sv
// Directed bench for dcoffset_loader with a step-level model checked every cycle.
module tb_dcoffset_loader;
  import dcoffset_pkg::*;

  localparam int STEP = 16;
  localparam int TICK = 64;
  localparam int EDLY = 2;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  dcoffset_loader_if bus();

  dcoffset_loader #(.ADDR(4'hA), .STEP(STEP), .TICK_DIV(TICK), .EN_DELAY(EDLY)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int n_chk = 0, n_fail = 0;
  int m_tgt = 'h800;
  int m_cur = 'h800, en_due = -1, cyc = 0, steps = 0, en_cnt = 0, ferr_cyc = 0;
  int mon_chk = 0, mon_fail = 0, exp_v;
  bit mon_en = 1'b0;

  function automatic int model_next(input int c, input int t);
    if (t > c) return c + ((t - c) < STEP ? (t - c) : STEP);
    if (t < c) return c - ((c - t) < STEP ? (c - t) : STEP);
    return c;
  endfunction

  always @(negedge Clock) begin
    if (!Reset_n) begin
      m_cur  = 'h800;
      en_due = -1;
    end else if (mon_en) begin
      cyc++;
      if (int'(bus.Dout) != m_cur) begin
        exp_v = model_next(m_cur, m_tgt);
        mon_chk++;
        if (int'(bus.Dout) != exp_v || en_due >= 0) begin
          mon_fail++;
          $display("FAIL step: Dout=%h expected %h (from %h toward %h, pending EN %0d)",
                   bus.Dout, exp_v, m_cur, m_tgt, en_due);
        end
        m_cur  = exp_v;
        en_due = cyc + EDLY;
        steps++;
      end
      mon_chk++;
      if (bus.EN !== (cyc == en_due)) begin
        mon_fail++;
        $display("FAIL en_timing: EN=%b expected %b at cycle %0d", bus.EN, (cyc == en_due), cyc);
      end
      if (cyc == en_due) begin
        en_due = -1;
        mon_chk++;
        if (bus.Busy !== 1'b1) begin
          mon_fail++;
          $display("FAIL busy_at_en: Busy=%b expected 1", bus.Busy);
        end
      end
      if (bus.EN === 1'b1) en_cnt++;
      if (bus.FrameErr === 1'b1) ferr_cyc++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic frame_begin(input logic [15:0] f, input int nbits);
    bus.CS_n = 1'b0;
    repeat (8) @(negedge Clock);
    for (int i = 0; i < nbits; i++) begin
      bus.SDI = f[15-i];
      repeat (4) @(negedge Clock);
      bus.SCK = 1'b1;
      repeat (4) @(negedge Clock);
      bus.SCK = 1'b0;
    end
    repeat (4) @(negedge Clock);
  endtask

  task automatic frame_end(input logic [15:0] f, input int nbits);
    bus.CS_n = 1'b1;
    if (nbits == 16 && f[15:12] == 4'hA) m_tgt = int'(f[11:0]);
    repeat (8) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [15:0] f, input int nbits);
    frame_begin(f, nbits);
    frame_end(f, nbits);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(m_cur == m_tgt && en_due < 0 && bus.Busy === 1'b0) && n < budget);
    chk(nm, int'(n < budget), 1);
    repeat (4) @(negedge Clock);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_dout"}, int'(bus.Dout), 'h800);
    chk({nm, "_en"}, int'(bus.EN), 0);
    chk({nm, "_busy"}, int'(bus.Busy), 0);
    chk({nm, "_ferr"}, int'(bus.FrameErr), 0);
  endtask

  initial begin
    int s0, e0, f0, n;
    bus.CS_n = 1'b1; bus.SCK = 1'b0; bus.SDI = 1'b0;
    repeat (5) @(negedge Clock);
    chk_reset_vals("in_reset");
    Reset_n = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock);
      if (bus.Dout !== 12'h800 || bus.EN !== 1'b0 || bus.Busy !== 1'b0) chk_reset_vals("quiet");
    end
    chk_reset_vals("quiet_end");

    // Upward slew 0x800 -> 0x900: 16 full steps
    s0 = steps; e0 = en_cnt;
    send_frame(16'hA900, 16);
    chk("busy_slewing", int'(bus.Busy), 1);
    wait_idle("up_timeout", 3000);
    chk("up_dout", int'(bus.Dout), 'h900);
    chk("up_model", m_cur, 'h900);
    chk("up_steps", steps - s0, 16);
    chk("up_ens", en_cnt - e0, 16);
    chk("up_busy", int'(bus.Busy), 0);

    // Reset in ALIGN, right after a Dout change and before its EN
    send_frame(16'hA000, 16);
    s0 = steps; n = 0;
    while (steps == s0 && n < 3000) begin @(negedge Clock); n++; end
    chk("align_wait", int'(n < 3000), 1);
    #1 Reset_n = 1'b0;
    #1 chk_reset_vals("rst_align");
    m_tgt = 'h800;
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    chk_reset_vals("post_rst_align");

    // Partial step down: 0x800 -> 0x7F8 in one move of 8
    s0 = steps; e0 = en_cnt;
    send_frame(16'hA7F8, 16);
    wait_idle("part_timeout", 1000);
    chk("part_dout", int'(bus.Dout), 'h7F8);
    chk("part_steps", steps - s0, 1);
    chk("part_ens", en_cnt - e0, 1);

    // Short frame and foreign address
    e0 = en_cnt; f0 = ferr_cyc;
    send_frame(16'hA123, 15);
    repeat (200) @(negedge Clock);
    chk("short_ferr", ferr_cyc - f0, 1);
    chk("short_dout", int'(bus.Dout), 'h7F8);
    chk("short_ens", en_cnt - e0, 0);
    send_frame(16'h5123, 16);
    repeat (200) @(negedge Clock);
    chk("addr_ferr", ferr_cyc - f0, 1);
    chk("addr_dout", int'(bus.Dout), 'h7F8);
    chk("addr_busy", int'(bus.Busy), 0);

    // Reset mid-frame drops the partial frame; the next frame lands cleanly
    frame_begin(16'hA123, 8);
    #1 Reset_n = 1'b0;
    #1 chk_reset_vals("rst_frame");
    m_tgt = 'h800;
    bus.CS_n = 1'b1;
    repeat (6) @(negedge Clock);
    Reset_n = 1'b1;
    f0 = ferr_cyc; s0 = steps;
    send_frame(16'hA810, 16);
    wait_idle("after_rst_timeout", 1000);
    chk("after_rst_dout", int'(bus.Dout), 'h810);
    chk("after_rst_steps", steps - s0, 1);
    chk("after_rst_ferr", ferr_cyc - f0, 0);

    // Retarget mid-slew: head for 0xFFF, then reverse to 0x000
    e0 = en_cnt;
    send_frame(16'hAFFF, 16);
    n = 0;
    while (en_cnt - e0 < 2 && n < 1000) begin @(negedge Clock); n++; end
    frame_begin(16'hA000, 16);
    e0 = en_cnt; n = 0;
    while (en_cnt == e0 && n < 500) begin @(negedge Clock); n++; end
    chk("retgt_en_wait", int'(n < 500), 1);
    chk("retgt_went_up", int'(int'(bus.Dout) > 'h830), 1);
    frame_end(16'hA000, 16);
    wait_idle("down_timeout", 20000);
    chk("down_dout", int'(bus.Dout), 'h000);

    // Same target again: nothing moves
    e0 = en_cnt; s0 = steps;
    send_frame(16'hA000, 16);
    repeat (200) @(negedge Clock);
    chk("same_ens", en_cnt - e0, 0);
    chk("same_steps", steps - s0, 0);
    chk("same_busy", int'(bus.Busy), 0);

    // Full scale 0x000 -> 0xFFF: 255 steps of 16 plus one of 15
    e0 = en_cnt; s0 = steps;
    send_frame(16'hAFFF, 16);
    wait_idle("full_timeout", 20000);
    chk("full_dout", int'(bus.Dout), 'hFFF);
    chk("full_steps", steps - s0, 256);
    chk("full_ens", en_cnt - e0, 256);
    chk("full_busy", int'(bus.Busy), 0);

    n_chk  += mon_chk;
    n_fail += mon_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcoffset_loader.md
Name: dcoffset_loader

Overview:
- Control-side producer for the DC-offset vertical path. It receives 16-bit offset frames from the front-panel MCU over a 3-wire serial link.
- It slews the applied 12-bit offset toward each new target in bounded steps, drives Dout, and issues a delayed one-cycle EN.
- The EN delay matches the two pipeline register stages ahead of the downstream load-enabled offset register, so that register captures each new step exactly once.

Parameters:
- ADDR, 4'hA, address nibble selecting the DC-offset register in a frame.
- STEP, 16, maximum code change per slew tick (1..2047).
- TICK_DIV, 64, Clock cycles per slew tick (>=4).
- EN_DELAY, 2, Clock cycles from a Dout update to the EN pulse.

Ports:
- Clock  in  1  system clock; all logic rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- SCK  in  1  MCU serial clock, asynchronous to Clock, at most Clock/8.
- SDI  in  1  MCU serial data, MSB first, sampled on SCK rise.
- CS_n  in  1  frame select, active-low.
- Dout  out  12  offset code, offset-binary, to the offset path data input.
- EN  out  1  load strobe to the offset path enable.
- Busy  out  1  high while a slew or an EN pulse is pending.
- FrameErr  out  1  one-cycle pulse when a malformed frame is rejected.

Behaviour:
- Reset (async assert, sync release): Dout=12'h800 (zero volts), current=target=12'h800, EN=0, Busy=0, FrameErr=0, bit count=0, FSM=IDLE, prescaler=0.
- Input sync: SCK, SDI and CS_n each pass through a 2-FF synchronizer. Edges are detected on the synced signals (3rd flop).
- Receive:
  - CS_n falling edge clears bit count.
  - Each SCK rising edge while CS_n is low shifts SDI into a 16-bit register (MSB first). Count saturates at 17.
  - On CS_n rising edge with count==16: frame = {addr[15:12], data[11:0]}. If addr==ADDR, target<=data. Any other addr is ignored silently.
  - On CS_n rising edge with count!=16: FrameErr pulses 1 cycle and the frame is discarded.
- Prescaler: free-running 0..TICK_DIV-1; tick = terminal count.
- FSM states:
  - IDLE: current==target. If a new target differs, go to SLEW.
  - SLEW: on tick, current <= current +/- min(STEP, |target-current|) and Dout <= new current; go to ALIGN.
  - ALIGN: hold Dout for EN_DELAY cycles, drive EN=1 for exactly one cycle, then return to SLEW if current!=target, else IDLE.
- Arithmetic:
  - Unsigned 12-bit with a 13-bit difference.
  - Never overshoots target; never wraps (0x000 and 0xFFF are reachable and never exceeded).
- Dout changes only in SLEW on a tick, so it is stable from the update through the EN cycle.
- Busy = (FSM!=IDLE) or (new target != current).
- New valid frame mid-slew or in ALIGN: target is replaced immediately. The current step completes with its EN, and the next step heads toward the new target.
- Frame with data == current target: no step and no EN.
- Reset mid-frame or mid-slew: the partial frame is dropped and all outputs return to reset values.
- Latency: first Dout change at the first tick after CS_n rise + 3 sync cycles. EN follows the Dout change by exactly EN_DELAY cycles.

Decomposition:
- Shared package dcoffset_pkg:
  - DAC_W=12, FRAME_W=16, ADDR_W=4.
  - DC_ZERO=12'h800.
  - FSM state enum {IDLE, SLEW, ALIGN}.
- One sub-module: serial_frame_rx. It contains the synchronizers, shift register, bit count, and frame-valid/FrameErr generation. It outputs a 1-cycle frame_valid with addr/data.
- The slew FSM, prescaler and EN delay stay in the top module.

Test Plan:
- Reset check: release Reset_n -> Dout=0x800, EN=0, Busy=0 and unchanged for 1000 cycles with CS_n high.
- Frame 0xA900 (STEP=16) -> 16 steps of +16, each EN exactly 2 cycles after its Dout change, one EN per step; final Dout=0x900; Busy falls after the last EN.
- Frame 0xA7F8 from 0x800 -> single partial step to 0x7F8 with one EN; no undershoot.
- Malformed frame: 15 SCK pulses then CS_n rise -> FrameErr 1-cycle pulse, Dout/target unchanged, no EN. Frame 0x5123 (wrong addr) -> no FrameErr, no change.
- Mid-slew retarget: 0xAFFF then 0xA000 after 3 steps -> direction reverses without a skipped EN. Later 0xAFFF from 0x000 reaches 0xFFF with no wrap; the step count equals ceil(4095/16)=256.
- Reset asserted mid-frame and mid-ALIGN -> outputs go to reset values immediately; the next full frame after release is received correctly.
